// File: rtl/pio_ser_deser.sv
// pio_ser_deser: serial-to-parallel PIO front end with word framing.
// Odd parity on a trailing serial bit is enabled by defining PIO_PARITY_EN.
module pio_ser_deser #(
  parameter int WORD_W   = 26,
  parameter int HOLD_CYC = 8,
  parameter int GAP_MAX  = 64
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              SER_SYNC,
  input  logic              SER_STB,
  input  logic              SER_DATA,
  output logic [WORD_W-1:0] G_DV,
  output logic [WORD_W-1:0] G_DVN,
  output logic              INFOV,
  output logic              FRM_ERR,
  output logic              PAR_ERR
);
`ifdef PIO_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int BW = $clog2(FRAME_W + 1);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [BW-1:0] LAST_B = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] LAST_G = GW'(GAP_MAX - 1);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLD_CYC);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;
  logic [WORD_W-1:0] dv_q;
  logic [BW-1:0]     bcnt_q;
  logic [GW-1:0]     gap_q;
  logic [HW-1:0]     hold_q;
  logic              infov_q;
  logic              frm_q;
  logic              last_bit;

  assign sr_d     = {SER_DATA, sr_q[WORD_W-1:1]};
  assign last_bit = (bcnt_q == LAST_B);

`ifdef PIO_PARITY_EN
  logic par_q;
  logic par_ok;
  // sr_q already holds all data bits when the parity strobe arrives
  assign par_ok  = ^{sr_q, SER_DATA};
  assign PAR_ERR = par_q;
`else
  assign PAR_ERR = 1'b0;
`endif

  assign G_DV    = dv_q;
  assign G_DVN   = ~dv_q;
  assign INFOV   = infov_q;
  assign FRM_ERR = frm_q;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dv_q    <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      infov_q <= 1'b0;
      frm_q   <= 1'b0;
`ifdef PIO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      frm_q <= 1'b0;
`ifdef PIO_PARITY_EN
      par_q <= 1'b0;
`endif
      if (SER_SYNC) begin
        // sync wins over a coincident strobe, whose bit opens the new word
        frm_q   <= (state_q == SHIFT);
        infov_q <= 1'b0;
        state_q <= SHIFT;
        gap_q   <= '0;
        bcnt_q  <= BW'(SER_STB);
        if (SER_STB) sr_q <= sr_d;
      end else begin
        unique case (state_q)
          IDLE: ;
          SHIFT: begin
            if (SER_STB) begin
              gap_q <= '0;
              if (last_bit) begin
`ifdef PIO_PARITY_EN
                if (par_ok) begin
                  dv_q    <= sr_q;
                  infov_q <= 1'b1;
                  hold_q  <= HOLD_L;
                  state_q <= HOLD;
                end else begin
                  par_q   <= 1'b1;
                  state_q <= IDLE;
                end
`else
                dv_q    <= sr_d;
                infov_q <= 1'b1;
                hold_q  <= HOLD_L;
                state_q <= HOLD;
`endif
              end else begin
                sr_q   <= sr_d;
                bcnt_q <= bcnt_q + 1'b1;
              end
            end else if (gap_q == LAST_G) begin
              frm_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          HOLD: begin
            if (hold_q == HW'(1)) begin
              infov_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pio_ser_deser.sv
// tb_pio_ser_deser: directed + random bench for pio_ser_deser.
// Outputs are checked against a queue-based word model every cycle.
module tb_pio_ser_deser;
  localparam int W    = 26;
  localparam int HOLD = 8;
  localparam int GAPM = 64;
`ifdef PIO_PARITY_EN
  localparam int FRAME_W = W + 1;
  localparam bit PAR_ON  = 1'b1;
`else
  localparam int FRAME_W = W;
  localparam bit PAR_ON  = 1'b0;
`endif

  logic         SIM_CLK;
  logic         SIM_RST;
  logic         SER_SYNC;
  logic         SER_STB;
  logic         SER_DATA;
  logic [W-1:0] G_DV;
  logic [W-1:0] G_DVN;
  logic         INFOV;
  logic         FRM_ERR;
  logic         PAR_ERR;

  pio_ser_deser #(.WORD_W(W), .HOLD_CYC(HOLD), .GAP_MAX(GAPM)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .SER_SYNC(SER_SYNC),
    .SER_STB (SER_STB),
    .SER_DATA(SER_DATA),
    .G_DV    (G_DV),
    .G_DVN   (G_DVN),
    .INFOV   (INFOV),
    .FRM_ERR (FRM_ERR),
    .PAR_ERR (PAR_ERR)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  int n_vec = 0;
  int n_bad = 0;

  // model: 0 idle, 1 receiving, 2 window open
  int           m_mode;
  logic         bits[$];
  int           m_gap;
  int           m_left;
  logic [W-1:0] m_dv;
  logic         m_infov;
  logic         m_frm;
  logic         m_par;

  task automatic chk_w(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    bits.delete();
    m_gap   = 0;
    m_left  = 0;
    m_dv    = '0;
    m_infov = 1'b0;
    m_frm   = 1'b0;
    m_par   = 1'b0;
  endtask

  task automatic model_step(input logic sy, input logic st, input logic d);
    int ones;
    m_frm = 1'b0;
    m_par = 1'b0;
    if (sy) begin
      m_frm   = (m_mode == 1);
      m_mode  = 1;
      m_infov = 1'b0;
      bits.delete();
      m_gap   = 0;
      if (st) bits.push_back(d);
    end else if (m_mode == 1) begin
      if (st) begin
        m_gap = 0;
        bits.push_back(d);
        if (bits.size() == FRAME_W) begin
          ones = 0;
          foreach (bits[i]) ones += int'(bits[i]);
          if (PAR_ON && (ones % 2 == 0)) begin
            m_par  = 1'b1;
            m_mode = 0;
          end else begin
            for (int i = 0; i < W; i++) m_dv[i] = bits[i];
            m_infov = 1'b1;
            m_left  = HOLD;
            m_mode  = 2;
          end
        end
      end else begin
        m_gap++;
        if (m_gap == GAPM) begin
          m_frm  = 1'b1;
          m_mode = 0;
        end
      end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_infov = 1'b0;
        m_mode  = 0;
      end
    end
  endtask

  task automatic check_all();
    chk_w("g_dv", G_DV, m_dv);
    chk_w("g_dvn", G_DVN, ~m_dv);
    chk_b("infov", INFOV, m_infov);
    chk_b("frm_err", FRM_ERR, m_frm);
    chk_b("par_err", PAR_ERR, m_par);
  endtask

  // one clock: drive, clock, update model, sample 1 ns after the edge
  task automatic cyc(input logic sy, input logic st, input logic d);
    SER_SYNC = sy;
    SER_STB  = st;
    SER_DATA = d;
    @(posedge SIM_CLK);
    model_step(sy, st, d);
    #1;
    SER_SYNC = 1'b0;
    SER_STB  = 1'b0;
    SER_DATA = 1'b0;
    check_all();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int from, input int to);
    for (int k = from; k < to; k++) cyc(1'b0, 1'b1, w[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_c;
  int           cnt;
  int           r;
  logic         par_b;

  initial begin
    SIM_RST  = 1'b0;
    SER_SYNC = 1'b0;
    SER_STB  = 1'b0;
    SER_DATA = 1'b0;
    model_reset();
    #12;
    chk_w("rst_dv", G_DV, '0);
    chk_w("rst_dvn", G_DVN, {W{1'b1}});
    chk_b("rst_infov", INFOV, 1'b0);
    chk_b("rst_frm", FRM_ERR, 1'b0);
    chk_b("rst_par", PAR_ERR, 1'b0);
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    @(posedge SIM_CLK);
    #1;

    // alternating pattern, back-to-back strobes
    w_a = 26'h2AAAAAA;
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_a, 0, W);
    chk_w("alt_dv", G_DV, 26'h2AAAAAA);
    chk_w("alt_dvn", G_DVN, 26'h1555555);
    chk_b("alt_infov", INFOV, 1'b1);
    cnt = 1;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (INFOV) cnt++;
    end
    chk_i("alt_infov_len", cnt, HOLD);

    // async reset mid-word
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'($urandom));
    #3;
    SIM_RST = 1'b0;
    #1;
    model_reset();
    chk_w("mid_rst_dv", G_DV, '0);
    chk_w("mid_rst_dvn", G_DVN, {W{1'b1}});
    chk_b("mid_rst_infov", INFOV, 1'b0);
    #2;
    SIM_RST = 1'b1;
    @(posedge SIM_CLK);
    #1;
    w_b = W'($urandom);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_b, 0, W);
    chk_w("post_rst_dv", G_DV, w_b);
    idle(HOLD + 2);

    // restart: sync coincident with a strobe mid-word
    w_a = W'($urandom);
    w_b = W'($urandom);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_a, 0, 12);
    cyc(1'b1, 1'b1, w_b[0]);
    chk_b("restart_frm", FRM_ERR, 1'b1);
    send_bits(w_b, 1, W);
    chk_w("restart_dv", G_DV, w_b);
    chk_b("restart_infov", INFOV, 1'b1);
    idle(HOLD + 2);

    // gap timeout
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(W'($urandom), 0, 5);
    cnt = 0;
    for (int k = 0; k < GAPM + 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (FRM_ERR) cnt++;
    end
    chk_i("gap_frm_cnt", cnt, 1);
    send_bits(W'($urandom), 0, W);
    chk_w("gap_dv_hold", G_DV, w_b);
    chk_b("gap_infov", INFOV, 1'b0);

    // sync during window, third INFOV cycle
    w_a = W'($urandom);
    w_c = W'($urandom);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_a, 0, W);
    idle(2);
    chk_b("hold3_infov", INFOV, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk_b("hold_sync_infov", INFOV, 1'b0);
    chk_b("hold_sync_frm", FRM_ERR, 1'b0);
    for (int k = 0; k < W; k++) begin
      idle($urandom_range(0, 3));
      if (k == W - 1) chk_w("hold_old_dv", G_DV, w_a);
      cyc(1'b0, 1'b1, w_c[k]);
    end
    chk_w("hold_new_dv", G_DV, w_c);
    idle(HOLD + 2);

`ifdef PIO_PARITY_EN
    w_a = 26'h0000001;
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_a, 0, W);
    cyc(1'b0, 1'b1, 1'b0);
    chk_b("par_ok_infov", INFOV, 1'b1);
    chk_w("par_ok_dv", G_DV, 26'h0000001);
    idle(HOLD + 2);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_a, 0, W);
    cyc(1'b0, 1'b1, 1'b1);
    chk_b("par_bad_err", PAR_ERR, 1'b1);
    chk_b("par_bad_infov", INFOV, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_b("par_bad_pulse", PAR_ERR, 1'b0);
    w_b = 26'h0000003;
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w_b, 0, W);
    cyc(1'b0, 1'b1, 1'b0);
    chk_w("par_bad_dv_keep", G_DV, 26'h0000001);
    idle(4);
`endif

    // random traffic against the model
    for (int n = 0; n < 40; n++) begin
      w_a = W'($urandom);
      par_b = ~(^w_a);
      if ($urandom_range(0, 4) == 0) par_b = ~par_b;
      cyc(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < FRAME_W; k++) begin
        r = $urandom_range(0, 99);
        if (r < 2) idle(GAPM + 2);
        else if (r < 4) cyc(1'b1, 1'b1, 1'($urandom));
        else if (r < 30) idle($urandom_range(1, 3));
        cyc(1'b0, 1'b1, (k < W) ? w_a[k] : par_b);
      end
      idle($urandom_range(0, HOLD + 2));
    end
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      cyc(r < 3, $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pio_ser_deser.md
# pio_ser_deser

Serial-to-parallel front end for the LVDA process-I/O (PIO) data path. It shifts the computer's serial data word in one bit per strobe and frames it. It then presents the word on the parallel data-valid lines (G1DV..GnDV and their complements) together with the INFOV information-valid window. The buffer and mode registers immediately downstream sample those lines under their address and timing gates.

## Interface
Parameters:
- WORD_W, 26, data bits per word; output bit i drives G(i+1)DV
- HOLD_CYC, 8, SIM_CLK cycles INFOV stays high per accepted word (≥1)
- GAP_MAX, 64, maximum SIM_CLK cycles between bit strobes inside a word before framing error (≥2)

Ports:
- SIM_CLK  in  1  system clock; all state updates on rising edge
- SIM_RST  in  1  reset; asynchronous, active-low
- SER_SYNC  in  1  start-of-word pulse, one cycle
- SER_STB  in  1  bit strobe, one cycle per serial bit
- SER_DATA  in  1  serial data bit, sampled when SER_STB=1
- G_DV  out  WORD_W  parallel data-valid lines
- G_DVN  out  WORD_W  bitwise complement of G_DV at all times
- INFOV  out  1  information-valid window for the current word
- FRM_ERR  out  1  one-cycle framing-error pulse
- PAR_ERR  out  1  one-cycle parity-error pulse (only with PIO_PARITY_EN)

## Operation
- States: IDLE, SHIFT, HOLD.
- Reset (SIM_RST=0, async) values:
  - G_DV=0 and G_DVN=all ones.
  - INFOV=0, FRM_ERR=0, PAR_ERR=0.
  - Bit counter=0, gap counter=0, state IDLE.
- IDLE:
  - SER_STB is ignored.
  - SER_SYNC moves the block to SHIFT and clears the bit and gap counters.
- SHIFT:
  - Each SER_STB shifts the shift register right, with SER_DATA entering at bit WORD_W-1. The bit counter increments.
  - After WORD_W shifts, the first received bit sits at bit 0 (G1DV).
  - Word complete at bit count = FRAME_W. FRAME_W = WORD_W, or WORD_W+1 with parity.
  - On completion: G_DV is loaded from the shift register, INFOV is set, the hold counter is loaded with HOLD_CYC, and the state becomes HOLD.
  - The gap counter increments every cycle without SER_STB and is cleared on SER_STB.
  - When the gap counter reaches GAP_MAX: FRM_ERR pulses, the state becomes IDLE, and G_DV is unchanged.
- HOLD:
  - The hold counter decrements each cycle.
  - At 1: INFOV clears and the state becomes IDLE.
  - SER_STB is ignored.
- SER_SYNC in SHIFT (mid-word): FRM_ERR pulses, the counters clear, and the block stays in SHIFT (restart). Partial data is discarded.
- SER_SYNC in HOLD: INFOV clears next cycle, the block enters SHIFT, and G_DV is retained.
- SER_SYNC and SER_STB in the same cycle: sync is applied first, and that strobe's bit is bit 1 of the new word (bit counter=1 after the edge).
- G_DV changes only on an accepted word completion. It holds through IDLE, errors and subsequent SHIFT.

## Timing
- Completion latency: G_DV, G_DVN and INFOV update on the edge that samples the final SER_STB. They are visible in the cycle after that strobe.
- INFOV is high for exactly HOLD_CYC cycles unless cut short by SER_SYNC.
- FRM_ERR and PAR_ERR are registered and high for exactly one cycle.
- Minimum word time is FRAME_W cycles (back-to-back strobes allowed).
- A new SER_SYNC is accepted the cycle after INFOV drops.

## Configuration
- Macro: PIO_PARITY_EN.
- Defined:
  - FRAME_W = WORD_W+1; the final serial bit is the parity bit.
  - Odd parity is required over the WORD_W data bits plus the parity bit.
  - On mismatch: PAR_ERR pulses on the completion edge, G_DV is not loaded, INFOV stays 0, and the state becomes IDLE.
  - The parity bit never appears on G_DV.
- Undefined:
  - FRAME_W = WORD_W.
  - No parity logic; PAR_ERR is tied 0.

## Test plan
- Reset mid-SHIFT (SIM_RST low between clock edges, after 10 bits) -> outputs immediately G_DV=0, G_DVN=all ones, INFOV=0; the next SER_SYNC starts a clean word.
- SER_SYNC, then 26 back-to-back strobes of pattern 0x2AAAAAA (first bit sent = bit 0) -> G_DV=0x2AAAAAA and G_DVN=0x1555555 one cycle after the last strobe; INFOV high for 8 cycles; FRM_ERR never set.
- SER_SYNC, 12 strobes, then a second SER_SYNC coincident with a strobe -> one FRM_ERR pulse; the word completes after 25 further strobes; G_DV equals the new word only.
- SER_SYNC, 5 strobes, then idle for 64 cycles -> FRM_ERR pulse, IDLE, G_DV holds the previous word; later strobes without sync are ignored.
- SER_SYNC during HOLD at the 3rd INFOV cycle -> INFOV low next cycle; new word shifts in; G_DV holds the old value until new completion.
- PIO_PARITY_EN: word 0x0000001 plus parity bit 0 -> accepted, INFOV high; same word plus parity 1 -> PAR_ERR one cycle, INFOV stays 0, G_DV unchanged.
